vdsu_8bit_div: RTL and testbench



---
 rtl/vdsu_8bit_div.sv | 132 +++++++++++++
 tb/tb_vdsu_8bit_div.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdsu_8bit_div.sv
// Sequential signed/unsigned 16-by-8 radix-2 restoring divider with start/busy/done handshake.
// Optional feature: define VDSU_DIV_ZERO_CHECK_EN for a 1-cycle divide-by-zero bypass.
module vdsu_8bit_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        control,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        ovf,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_reg, state_next;
  logic        sign_q_reg, sign_r_reg, ovf_pend_reg, dz_pend_reg;
  logic [15:0] dvd_reg;
  logic [7:0]  dmag_reg;
  logic [8:0]  rem_reg;
  logic [3:0]  cnt_reg;
  logic        busy_reg, done_reg, ovf_reg, div_zero_reg;
  logic [15:0] quot_reg;
  logic [7:0]  remd_reg;

  logic        dz_det;
  logic [8:0]  r_shift, r_sub;
  logic        q_bit;
  logic [15:0] dvd_mag;
  logic [7:0]  dsr_mag;

`ifdef VDSU_DIV_ZERO_CHECK_EN
  assign dz_det = (divisor == 8'h00);
`else
  assign dz_det = 1'b0;
`endif

  always_comb begin
    dvd_mag = (control && dividend[15]) ? (16'h0000 - dividend) : dividend;
    dsr_mag = (control && divisor[7])   ? (8'h00 - divisor)     : divisor;
    r_shift = {rem_reg[7:0], dvd_reg[15]};
    r_sub   = r_shift - {1'b0, dmag_reg};
    q_bit   = (r_shift >= {1'b0, dmag_reg});
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = dz_det ? FIX : CALC;
      CALC:    if (cnt_reg == 4'd15) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient shift register: one bit
  // leaves at the top and one quotient bit enters at the bottom each CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      ovf_pend_reg <= 1'b0;
      dz_pend_reg  <= 1'b0;
      dvd_reg      <= '0;
      dmag_reg     <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      div_zero_reg <= 1'b0;
      quot_reg     <= '0;
      remd_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sign_q_reg   <= control & (dividend[15] ^ divisor[7]);
            sign_r_reg   <= control & dividend[15];
            ovf_pend_reg <= control & (dividend == 16'h8000) & (divisor == 8'hFF);
            dz_pend_reg  <= dz_det;
            // On a zero divisor the raw dividend is kept so its low byte can be returned.
            dvd_reg      <= dz_det ? dividend : dvd_mag;
            dmag_reg     <= dsr_mag;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            ovf_reg      <= 1'b0;
            div_zero_reg <= 1'b0;
          end
        end
        CALC: begin
          rem_reg <= q_bit ? r_sub : r_shift;
          dvd_reg <= {dvd_reg[14:0], q_bit};
          cnt_reg <= cnt_reg + 4'd1;
        end
        FIX: begin
          if (dz_pend_reg) begin
            quot_reg     <= 16'hFFFF;
            remd_reg     <= dvd_reg[7:0];
            div_zero_reg <= 1'b1;
          end else begin
            quot_reg <= sign_q_reg ? (16'h0000 - dvd_reg) : dvd_reg;
            remd_reg <= sign_r_reg ? (8'h00 - rem_reg[7:0]) : rem_reg[7:0];
            ovf_reg  <= ovf_pend_reg;
          end
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quot_reg;
  assign remainder = remd_reg;
  assign ovf       = ovf_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_vdsu_8bit_div.sv
// Self-checking bench for vdsu_8bit_div: directed vectors, randomized ops against an
// arithmetic reference model, handshake, back-to-back and mid-operation reset.
module tb_vdsu_8bit_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        control = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, ovf, div_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vdsu_8bit_div dut (
    .clk(clk), .rst(rst), .start(start), .control(control),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .ovf(ovf), .div_zero(div_zero)
  );

  // Reference: plain integer division (truncating toward zero, remainder follows dividend).
  function automatic void model(input logic ctl, input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r, output logic o);
    int sa, sb, qi, ri;
    if (ctl) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    qi = sa / sb;
    ri = sa % sb;
    q = qi[15:0];
    r = ri[7:0];
    o = ctl && (a == 16'h8000) && (b == 8'hFF);
  endfunction

  // Issues one operation and waits (bounded) for done; lat = edges from start edge to done, -1 on timeout.
  task automatic do_op(input logic ctl, input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r, output logic o,
                       output logic z, output int lat);
    @(negedge clk);
    start = 1'b1; control = ctl; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; control = ~ctl; dividend = ~a; divisor = ~b;
    lat = -1; q = '0; r = '0; o = 1'b0; z = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k; q = quotient; r = remainder; o = ovf; z = div_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, ovf, div_zero} !== 28'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, want all 0",
               busy, done, quotient, remainder, ovf, div_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned_timing;
    int first_done;
    int busy_err;
    @(negedge clk);
    start = 1'b1; control = 1'b0; dividend = 16'd1000; divisor = 8'd7;
    first_done = -1; busy_err = 0;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k <= 16 && (busy !== 1'b1 || done !== 1'b0)) busy_err++;
      if (done === 1'b1 && first_done < 0) first_done = k;
      if (k == 17 && busy !== 1'b0) busy_err++;
      if (k == 17) begin
        total++;
        if (quotient !== 16'h008E || remainder !== 8'h06 || ovf !== 1'b0) begin
          bad++;
          $display("FAIL unsigned_1000_7: got q=%h r=%h ovf=%b, want q=008e r=06 ovf=0",
                   quotient, remainder, ovf);
        end
      end
      if (k == 18) begin
        total++;
        if (done !== 1'b0) begin
          bad++;
          $display("FAIL done_pulse_width: done=%b after E18, want 0", done);
        end
      end
    end
    total++;
    if (first_done != 17) begin
      bad++;
      $display("FAIL unsigned_latency: done at edge %0d, want 17", first_done);
    end
    total++;
    if (busy_err != 0) begin
      bad++;
      $display("FAIL busy_window: %0d busy/done errors over E0..E17, want 0", busy_err);
    end
  endtask

  task automatic test_signed_vectors;
    logic        ctl_t [3];
    logic [15:0] a_t [3], q_t [3];
    logic [7:0]  b_t [3], r_t [3];
    logic [15:0] q;
    logic [7:0]  r;
    logic        o, z;
    int          lat;
    ctl_t = '{1'b1, 1'b1, 1'b0};
    a_t   = '{16'hFC18, 16'h03E8, 16'hFC18};
    b_t   = '{8'h07, 8'hF9, 8'hF9};
    q_t   = '{16'hFF72, 16'hFF72, 16'h0103};
    r_t   = '{8'hFA, 8'h06, 8'h2D};
    for (int i = 0; i < 3; i++) begin
      do_op(ctl_t[i], a_t[i], b_t[i], q, r, o, z, lat);
      total++;
      if (q !== q_t[i] || r !== r_t[i] || o !== 1'b0 || lat != 17) begin
        bad++;
        $display("FAIL signed_vec%0d: got q=%h r=%h ovf=%b lat=%0d, want q=%h r=%h ovf=0 lat=17",
                 i, q, r, o, lat, q_t[i], r_t[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [15:0] q;
    logic [7:0]  r;
    logic        o, z;
    int          lat;
    do_op(1'b1, 16'h8000, 8'hFF, q, r, o, z, lat);
    total++;
    if (q !== 16'h8000 || r !== 8'h00 || o !== 1'b1) begin
      bad++;
      $display("FAIL overflow: got q=%h r=%h ovf=%b, want q=8000 r=00 ovf=1", q, r, o);
    end
    do_op(1'b1, 16'h0010, 8'h04, q, r, o, z, lat);
    total++;
    if (q !== 16'h0004 || r !== 8'h00 || o !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear: got q=%h r=%h ovf=%b, want q=0004 r=00 ovf=0", q, r, o);
    end
  endtask

  task automatic test_random;
    logic [15:0] a, q, eq;
    logic [7:0]  b, r, er;
    logic        ctl, o, eo, z;
    int          lat;
    for (int i = 0; i < 30; i++) begin
      ctl = 1'($urandom_range(0, 1));
      a   = 16'($urandom);
      b   = 8'($urandom_range(1, 255));
      if (i % 10 == 9) begin ctl = 1'b1; a = 16'h8000; b = 8'($urandom_range(0, 1) ? 8'hFF : 8'h80); end
      model(ctl, a, b, eq, er, eo);
      do_op(ctl, a, b, q, r, o, z, lat);
      total++;
      if (q !== eq || r !== er || o !== eo || z !== 1'b0 || lat != 17) begin
        bad++;
        $display("FAIL random%0d ctl=%b %h/%h: got q=%h r=%h ovf=%b dz=%b lat=%0d, want q=%h r=%h ovf=%b dz=0 lat=17",
                 i, ctl, a, b, q, r, o, z, lat, eq, er, eo);
      end
    end
  endtask

  task automatic test_hold_start;
    logic [15:0] eq, a2;
    logic [7:0]  er, b2;
    logic        eo, c2;
    int          lat;
    @(negedge clk);
    start = 1'b1; control = 1'b1; dividend = 16'hFC18; divisor = 8'h07;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      control = 1'($urandom_range(0, 1)); dividend = 16'($urandom); divisor = 8'($urandom_range(1, 255));
    end
    total++;
    if (lat != 17 || quotient !== 16'hFF72 || remainder !== 8'hFA) begin
      bad++;
      $display("FAIL hold_start_first: got q=%h r=%h lat=%0d, want q=ff72 r=fa lat=17", quotient, remainder, lat);
    end
    // start is still high in the done cycle, so these operands start the next op.
    c2 = control; a2 = dividend; b2 = divisor;
    model(c2, a2, b2, eq, er, eo);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; dividend = 16'h0; divisor = 8'h0; end
      if (done) begin lat = k; break; end
    end
    total++;
    if (lat != 18 || quotient !== eq || remainder !== er || ovf !== eo) begin
      bad++;
      $display("FAIL hold_start_second: got q=%h r=%h ovf=%b lat=%0d, want q=%h r=%h ovf=%b lat=18",
               quotient, remainder, ovf, lat, eq, er, eo);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] q;
    logic [7:0]  r;
    logic        o, z;
    int          lat;
    do_op(1'b0, 16'd1000, 8'd7, q, r, o, z, lat);
    total++;
    if (lat != 17 || q !== 16'h008E || r !== 8'h06) begin
      bad++;
      $display("FAIL b2b_first: got q=%h r=%h lat=%0d, want q=008e r=06 lat=17", q, r, lat);
    end
    start = 1'b1; control = 1'b0; dividend = 16'd255; divisor = 8'd16;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin lat = k; break; end
    end
    total++;
    if (lat != 18 || quotient !== 16'h000F || remainder !== 8'h0F) begin
      bad++;
      $display("FAIL b2b_second: got q=%h r=%h lat=%0d, want q=000f r=0f lat=18", quotient, remainder, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] q;
    logic [7:0]  r;
    logic        o, z, saw_done;
    int          lat;
    @(negedge clk);
    start = 1'b1; control = 1'b0; dividend = 16'd1000; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, ovf, div_zero} !== 28'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, want all 0",
               busy, done, quotient, remainder, ovf, div_zero);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_no_done: activity=%b after reset, want 0", saw_done);
    end
    do_op(1'b0, 16'd255, 8'd255, q, r, o, z, lat);
    total++;
    if (q !== 16'h0001 || r !== 8'h00 || lat != 17) begin
      bad++;
      $display("FAIL reset_mid_fresh: got q=%h r=%h lat=%0d, want q=0001 r=00 lat=17", q, r, lat);
    end
  endtask

  task automatic test_div_zero;
    logic [15:0] q;
    logic [7:0]  r;
    logic        o, z;
    int          lat;
    do_op(1'b0, 16'h1234, 8'h00, q, r, o, z, lat);
`ifdef VDSU_DIV_ZERO_CHECK_EN
    total++;
    if (lat != 1 || q !== 16'hFFFF || r !== 8'h34 || z !== 1'b1) begin
      bad++;
      $display("FAIL div_zero: got q=%h r=%h dz=%b lat=%0d, want q=ffff r=34 dz=1 lat=1", q, r, z, lat);
    end
`else
    total++;
    if (lat != 17 || z !== 1'b0) begin
      bad++;
      $display("FAIL div_zero_off: got dz=%b lat=%0d, want dz=0 lat=17", z, lat);
    end
`endif
    do_op(1'b0, 16'd100, 8'd9, q, r, o, z, lat);
    total++;
    if (q !== 16'd11 || r !== 8'd1 || z !== 1'b0) begin
      bad++;
      $display("FAIL div_zero_clear: got q=%h r=%h dz=%b, want q=000b r=01 dz=0", q, r, z);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_timing();
    test_signed_vectors();
    test_overflow();
    test_random();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    test_div_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
